// File: rtl/hash_result_collector.sv
// Result collector for the hash table core: FWFT result FIFO with status encoding,
// back-pressure to the core and saturating success/error counters.
module hash_result_collector #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tbl_valid_i,
    input  logic [DATA_WIDTH-1:0]         tbl_read_data_i,
    input  logic                          tbl_no_deletion_target_i,
    input  logic                          tbl_no_write_space_i,
    input  logic                          tbl_no_element_found_i,
    input  logic                          tbl_key_already_present_i,
    output logic                          tbl_ready_o,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [DATA_WIDTH-1:0]         res_data_o,
    output logic [2:0]                    res_status_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    input  logic                          stat_clear_i,
    output logic [STAT_WIDTH-1:0]         stat_ok_o,
    output logic [STAT_WIDTH-1:0]         stat_err_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned EntW = DATA_WIDTH + 3;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

    logic [EntW-1:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic [STAT_WIDTH-1:0] stat_ok_q, stat_ok_d;
    logic [STAT_WIDTH-1:0] stat_err_q, stat_err_d;
    logic [2:0]            status;
    logic [EntW-1:0]       head;
    logic                  push, pop;

    // Ready depends on registered occupancy only, never on the consumer side.
    assign tbl_ready_o = (level_q < LvlFull);
    assign res_valid_o = (level_q != '0);
    assign push        = tbl_valid_i && tbl_ready_o;
    assign pop         = res_valid_o && res_ready_i;
    assign level_o     = level_q;
    assign stat_ok_o   = stat_ok_q;
    assign stat_err_o  = stat_err_q;

    assign head         = mem_q[rd_ptr_q];
    assign res_data_o   = res_valid_o ? head[DATA_WIDTH-1:0] : '0;
    assign res_status_o = res_valid_o ? head[EntW-1:DATA_WIDTH] : 3'd0;

    // Anything other than zero or exactly one flag is a protocol error (7).
    always_comb begin
        status = 3'd7;
        case ({tbl_key_already_present_i, tbl_no_element_found_i,
               tbl_no_write_space_i, tbl_no_deletion_target_i})
            4'b0000: status = 3'd0;
            4'b0001: status = 3'd1;
            4'b0010: status = 3'd2;
            4'b0100: status = 3'd3;
            4'b1000: status = 3'd4;
            default: status = 3'd7;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_comb begin
        stat_ok_d  = stat_ok_q;
        stat_err_d = stat_err_q;
        if (stat_clear_i) begin
            stat_ok_d  = '0;
            stat_err_d = '0;
        end else if (push) begin
            if (status == 3'd0) begin
                if (stat_ok_q != '1) begin
                    stat_ok_d = stat_ok_q + STAT_WIDTH'(1);
                end
            end else if (stat_err_q != '1) begin
                stat_err_d = stat_err_q + STAT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            stat_ok_q  <= '0;
            stat_err_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            stat_ok_q  <= stat_ok_d;
            stat_err_q <= stat_err_d;
        end
    end

    // Storage is not reset; empty reads are masked to zero above.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= {status, tbl_read_data_i};
        end
    end

endmodule

// File: tb/tb_hash_result_collector.sv
// Randomized bench for hash_result_collector against a queue-based reference model.
module tb_hash_result_collector;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int SW    = 4;
    localparam int SMAX  = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          tbl_valid_i;
    logic [DW-1:0] tbl_read_data_i;
    logic          tbl_ndt_i, tbl_nws_i, tbl_nef_i, tbl_kap_i;
    logic          tbl_ready_o;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [DW-1:0] res_data_o;
    logic [2:0]    res_status_o;
    logic [3:0]    level_o;
    logic          stat_clear_i;
    logic [SW-1:0] stat_ok_o, stat_err_o;

    always #5 clk = ~clk;

    hash_result_collector #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .STAT_WIDTH (SW)
    ) u_dut (
        .clk                       (clk),
        .reset                     (reset),
        .tbl_valid_i               (tbl_valid_i),
        .tbl_read_data_i           (tbl_read_data_i),
        .tbl_no_deletion_target_i  (tbl_ndt_i),
        .tbl_no_write_space_i      (tbl_nws_i),
        .tbl_no_element_found_i    (tbl_nef_i),
        .tbl_key_already_present_i (tbl_kap_i),
        .tbl_ready_o               (tbl_ready_o),
        .res_valid_o               (res_valid_o),
        .res_ready_i               (res_ready_i),
        .res_data_o                (res_data_o),
        .res_status_o              (res_status_o),
        .level_o                   (level_o),
        .stat_clear_i              (stat_clear_i),
        .stat_ok_o                 (stat_ok_o),
        .stat_err_o                (stat_err_o)
    );

    logic [DW+2:0] mq[$];
    int m_ok, m_err;
    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;
    int lvl_ref;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_status(input logic [3:0] f);
        int n = 0;
        for (int i = 0; i < 4; i++) if (f[i]) n++;
        if (n == 0) return 3'd0;
        if (n > 1) return 3'd7;
        for (int i = 0; i < 4; i++) if (f[i]) return 3'(i + 1);
        return 3'd7;
    endfunction

    task automatic check_outputs();
        int sz = mq.size();
        check("level", 64'(level_o), 64'(sz));
        check("res_valid", 64'(res_valid_o), 64'(sz != 0));
        check("tbl_ready", 64'(tbl_ready_o), 64'(sz < DEPTH));
        check("res_data", 64'(res_data_o), (sz != 0) ? 64'(mq[0][DW-1:0]) : 64'd0);
        check("res_status", 64'(res_status_o), (sz != 0) ? 64'(mq[0][DW+2:DW]) : 64'd0);
        check("stat_ok", 64'(stat_ok_o), 64'(m_ok));
        check("stat_err", 64'(stat_err_o), 64'(m_err));
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [3:0] f, input bit rdy);
        tbl_valid_i     = v;
        tbl_read_data_i = d;
        {tbl_kap_i, tbl_nef_i, tbl_nws_i, tbl_ndt_i} = f;
        res_ready_i     = rdy;
    endtask

    task automatic cycle();
        bit do_push, do_pop;
        logic [DW+2:0] ent;
        #1;
        if (armed) check("ready_pre_edge", 64'(tbl_ready_o), 64'(mq.size() < DEPTH));
        do_push = tbl_valid_i && (mq.size() < DEPTH);
        do_pop  = res_ready_i && (mq.size() != 0);
        ent = {model_status({tbl_kap_i, tbl_nef_i, tbl_nws_i, tbl_ndt_i}), tbl_read_data_i};
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_ok  = 0;
            m_err = 0;
        end else begin
            if (do_pop) mq.delete(0);
            if (do_push) mq.push_back(ent);
            if (stat_clear_i) begin
                m_ok  = 0;
                m_err = 0;
            end else if (do_push) begin
                if (ent[DW+2:DW] == 3'd0) m_ok = (m_ok < SMAX) ? m_ok + 1 : SMAX;
                else m_err = (m_err < SMAX) ? m_err + 1 : SMAX;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic drain();
        int budget = 0;
        drive(0, '0, 4'b0, 1);
        while (mq.size() != 0 && budget < 3 * DEPTH) begin
            cycle();
            budget++;
        end
        check("drain_done", 64'(mq.size()), 64'd0);
    endtask

    initial begin
        m_ok = 0;
        m_err = 0;
        reset = 1'b1;
        stat_clear_i = 1'b0;
        drive(0, '0, 4'b0, 0);
        cycle();
        cycle();
        reset = 1'b0;
        armed = 1'b1;

        // Three OK pushes held in the FIFO
        drive(1, 32'h11, 4'b0, 0); cycle();
        drive(1, 32'h22, 4'b0, 0); cycle();
        drive(1, 32'h33, 4'b0, 0); cycle();
        check("t1_level", 64'(level_o), 64'd3);
        check("t1_ready", 64'(tbl_ready_o), 64'd1);
        check("t1_head", 64'(res_data_o), 64'h11);
        check("t1_status", 64'(res_status_o), 64'd0);
        check("t1_ok", 64'(stat_ok_o), 64'd3);

        // Single flag then two flags
        drive(1, 32'h44, 4'b0100, 0); cycle();
        drive(1, 32'h55, 4'b1010, 0); cycle();
        check("t2_err", 64'(stat_err_o), 64'd2);
        check("t2_ok", 64'(stat_ok_o), 64'd3);
        drive(0, '0, 4'b0, 1);
        for (int i = 0; i < 3; i++) cycle();
        check("t2_status3", 64'(res_status_o), 64'd3);
        cycle();
        check("t2_status7", 64'(res_status_o), 64'd7);
        check("t2_data55", 64'(res_data_o), 64'h55);
        drain();

        // Fill to full, ignored extra push, one pop
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h100 + 32'(i), 4'b0, 0);
            cycle();
        end
        check("t3_full_ready", 64'(tbl_ready_o), 64'd0);
        drive(1, 32'hDEAD, 4'b0, 0); cycle();
        check("t3_ignored_level", 64'(level_o), 64'd8);
        drive(0, '0, 4'b0, 1); cycle();
        check("t3_ready_after_pop", 64'(tbl_ready_o), 64'd1);
        check("t3_head2", 64'(res_data_o), 64'h101);

        // Streaming push and pop across pointer wrap
        lvl_ref = mq.size();
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h200 + 32'(i), 4'b0, 1);
            cycle();
            check("t4_level_const", 64'(level_o), 64'(lvl_ref));
        end
        drain();

        // Saturation and clear priority
        stat_clear_i = 1'b1; drive(0, '0, 4'b0, 1); cycle();
        stat_clear_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1, 32'h300 + 32'(i), 4'b0, 1);
            cycle();
        end
        check("t5_ok_sat", 64'(stat_ok_o), 64'd15);
        stat_clear_i = 1'b1; drive(1, 32'h3FF, 4'b0, 1); cycle();
        stat_clear_i = 1'b0;
        check("t5_ok_cleared", 64'(stat_ok_o), 64'd0);
        drain();

        // Reset with entries stored and a push pending
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h400 + 32'(i), 4'(i), 0);
            cycle();
        end
        reset = 1'b1; drive(1, 32'h4FF, 4'b0, 0); cycle();
        reset = 1'b0;
        check("t6_level", 64'(level_o), 64'd0);
        check("t6_valid", 64'(res_valid_o), 64'd0);
        check("t6_ready", 64'(tbl_ready_o), 64'd1);
        check("t6_ok", 64'(stat_ok_o), 64'd0);
        check("t6_err", 64'(stat_err_o), 64'd0);

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 600; i++) begin
            int ph = (i / 50) % 3;
            logic [3:0] f;
            for (int b = 0; b < 4; b++) f[b] = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 9) < ((ph == 0) ? 8 : 5), $urandom, f,
                  $urandom_range(0, 9) < ((ph == 1) ? 8 : 4));
            stat_clear_i = ($urandom_range(0, 39) == 0);
            reset        = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
        stat_clear_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
